// File: rtl/logic_accum_n_bit.sv
// Bitwise burst reducer: accepts (len+1) words and emits one AND/OR/XOR/NAND result.
// Optional out_parity output is enabled by defining LOGIC_ACCUM_PARITY_EN.
module logic_accum_n_bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef LOGIC_ACCUM_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  state_t           state;
  state_t           state_next;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] identity;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             last_word;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; the producer holds data stable while valid is high and ready is low.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept    = in_valid & in_ready;
  assign last_word = accept & (cnt == '0);

  // AND-family reductions start from all ones, OR/XOR from all zeros.
  assign identity = ((op_t'(op) == OP_AND) || (op_t'(op) == OP_NAND)) ? '1 : '0;

  always_comb begin
    acc_next = acc;
    case (op_q)
      OP_AND, OP_NAND: acc_next = acc & in_data;
      OP_OR:           acc_next = acc | in_data;
      OP_XOR:          acc_next = acc ^ in_data;
      default:         acc_next = acc;
    endcase
  end

  assign result = (op_q == OP_NAND) ? ~acc_next : acc_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)                  state_next = ACCUM;
      ACCUM:   if (last_word)              state_next = DONE;
      DONE:    if (out_ready)              state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_AND;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            cnt  <= len;
            acc  <= identity;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            // The counter leaves ACCUM at zero, so it never wraps.
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end
            if (last_word) begin
              out_data <= result;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOGIC_ACCUM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (state == ACCUM && last_word) begin
      out_parity <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_logic_accum_n_bit.sv
// Randomized and directed bench for logic_accum_n_bit with a reduction reference model.
module tb_logic_accum_n_bit;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef LOGIC_ACCUM_PARITY_EN
  logic             out_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] word_mem [DEPTH];
  int               stall_before [DEPTH];
  bit               scramble;

  logic_accum_n_bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef LOGIC_ACCUM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: fold the burst with the selected bitwise operator.
  function automatic logic [WIDTH-1:0] ref_reduce(input logic [1:0] o, input int n);
    logic [WIDTH-1:0] r;
    r = (o == 2'd0 || o == 2'd3) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    for (int i = 0; i <= n; i++) begin
      case (o)
        2'd1:    r = r | word_mem[i];
        2'd2:    r = r ^ word_mem[i];
        default: r = r & word_mem[i];
      endcase
    end
    if (o == 2'd3) r = ~r;
    return r;
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < DEPTH; i++) stall_before[i] = 0;
  endtask

  task automatic scramble_inputs();
    if (scramble) begin
      op        = 2'($urandom);
      len       = CNT_W'($urandom);
      start     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Driver: one full burst with stalls, result check, hold and handshake.
  task automatic run_burst(input logic [1:0] o, input int l, input int hold,
                           input bit start_in_done, input string tag);
    logic [WIDTH-1:0] held;
    exp_q.push_back(ref_reduce(o, l));
    @(negedge clk);
    start = 1'b1; op = o; len = CNT_W'(l); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s enter_accum: busy=%b in_ready=%b required 1/1", tag, busy, in_ready);
    end
    for (int i = 0; i <= l; i++) begin
      repeat (stall_before[i]) begin
        in_valid = 1'b0; in_data = WIDTH'($urandom);
        scramble_inputs();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s stall%0d: in_ready=%b out_valid=%b required 1/0", tag, i, in_ready, out_valid);
        end
      end
      in_valid = 1'b1; in_data = word_mem[i];
      scramble_inputs();
      @(negedge clk);
      if (i < l) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s early_done word%0d: out_valid=%b required 0", tag, i, out_valid);
        end
      end
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_q[0]) begin
      errors++;
      $display("FAIL %s result: out_valid=%b in_ready=%b out_data=%b required 1/0/%b",
               tag, out_valid, in_ready, out_data, exp_q[0]);
    end
`ifdef LOGIC_ACCUM_PARITY_EN
    checks++;
    if (out_parity !== ^exp_q[0]) begin
      errors++;
      $display("FAIL %s parity: out_parity=%b required %b", tag, out_parity, ^exp_q[0]);
    end
`endif
    held = exp_q[0];
    repeat (hold) begin
      if (start_in_done) start = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL %s hold: out_valid=%b busy=%b out_data=%b required 1/1/%b",
                 tag, out_valid, busy, out_data, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: out_valid=%b busy=%b required 0/0", tag, out_valid, busy);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b out_data=%b required 0/0/0/0000",
               in_ready, out_valid, busy, out_data);
    end
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_ready: out_valid=%b busy=%b in_ready=%b required 0/0/0",
               out_valid, busy, in_ready);
    end
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_and();
    scramble = 1'b0; clear_stalls();
    word_mem[0] = 4'b1111; word_mem[1] = 4'b0011;
    run_burst(2'd0, 1, 0, 1'b0, "and_len1");
  endtask

  task automatic test_or_hold();
    scramble = 1'b0; clear_stalls();
    word_mem[0] = 4'b1100; word_mem[1] = 4'b0011; word_mem[2] = 4'b0000;
    run_burst(2'd1, 2, 3, 1'b0, "or_hold");
  endtask

  task automatic test_xor_stall();
    scramble = 1'b0; clear_stalls();
    word_mem[0] = 4'b0101; word_mem[1] = 4'b0011; word_mem[2] = 4'b1111; word_mem[3] = 4'b0000;
    stall_before[2] = 2;
    run_burst(2'd2, 3, 0, 1'b0, "xor_stall");
  endtask

  task automatic test_nand_start_in_done();
    scramble = 1'b0; clear_stalls();
    word_mem[0] = 4'b0101;
    run_burst(2'd3, 0, 2, 1'b1, "nand_len0");
  endtask

  task automatic test_full_depth();
    scramble = 1'b0; clear_stalls();
    for (int i = 0; i < DEPTH; i++) word_mem[i] = 4'b1111;
    word_mem[9] = 4'b1101;
    run_burst(2'd0, DEPTH - 1, 0, 1'b0, "and_full");
  endtask

  task automatic test_reset_abort();
    scramble = 1'b0; clear_stalls();
    @(negedge clk);
    start = 1'b1; op = 2'd1; len = 4'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 4'b1100;
    @(negedge clk);
    in_data = 4'b1000;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b busy=%b out_data=%b required 0/0/0/0000",
               in_ready, out_valid, busy, out_data);
    end
`ifdef LOGIC_ACCUM_PARITY_EN
    checks++;
    if (out_parity !== 1'b0) begin
      errors++;
      $display("FAIL abort_parity: out_parity=%b required 0", out_parity);
    end
`endif
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    word_mem[0] = 4'b0001; word_mem[1] = 4'b0010;
    run_burst(2'd1, 1, 0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    scramble = 1'b1;
    for (int b = 0; b < 24; b++) begin
      int l;
      logic [1:0] o;
      o = 2'($urandom);
      l = (b == 0) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] = WIDTH'($urandom);
        stall_before[i] = int'($urandom_range(0, 2));
      end
      run_burst(o, l, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end
    scramble = 1'b0;
  endtask

  task automatic test_back_to_back();
    scramble = 1'b0; clear_stalls();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < DEPTH; i++) word_mem[i] = WIDTH'($urandom);
      run_burst(2'(b), b + 1, 0, 1'b0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or_hold();
    test_xor_stall();
    test_nand_start_in_done();
    test_full_depth();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_accum_n_bit.md
Name: logic_accum_n_bit

Overview:
- Parametrised, sequential successor to the team's 4-bit bitwise gate blocks.
- Accepts a burst of (len+1) operand words over a valid/ready stream.
- Reduces the burst bitwise with a selectable operation (AND, OR, XOR, NAND) and presents one registered result word through an output valid/ready handshake.
- Sits between an operand source and a result consumer in the classroom datapath exercises.

Parameters:
- WIDTH, 4, operand and result width in bits.
- CNT_W, 4, width of the len port; a burst is at most 2^CNT_W words.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  begin a burst; sampled only in IDLE
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; captured with start
- len  input  CNT_W  words in burst minus one; captured with start
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  operand word
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  reduction result
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, rst=1):
  - State becomes IDLE.
  - in_ready=0, out_valid=0, busy=0, out_data=0.
  - Accumulator, counter and captured op/len clear to 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 captures op and len, and loads the counter with len.
  - The accumulator loads the identity value: all ones for AND/NAND, all zeros for OR/XOR.
  - Next state is ACCUM.
- ACCUM:
  - in_ready=1.
  - A word is accepted only on in_valid & in_ready. Each accepted word updates the accumulator: acc&d for AND/NAND, acc|d for OR, acc^d for XOR.
  - Counter decrements on each accept.
  - When the word accepted has counter==0, it is the last word. On that edge out_data loads the final value, inverted for NAND, and the state moves to DONE.
  - Cycles with in_valid=0 stall with no state change.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data is held stable until out_valid & out_ready, then the state returns to IDLE.
- Latency: out_valid rises the cycle after the last accepted word.
- Throughput: one word per cycle.
- Minimum cycles per burst: 1 (start) + (len+1) accept cycles + 1 cycle in DONE, i.e. len+3.
- Boundaries:
  - len=0 gives a single-word burst; NAND result is ~in_data.
  - len=2^CNT_W-1 gives a full-depth burst; the counter must not wrap before the last word.
  - start in ACCUM or DONE is ignored.
  - op and len changing mid-burst have no effect, because the captured copies are used.
  - out_ready while not in DONE is ignored.
  - start asserted in the same cycle DONE completes its handshake is not accepted; it must be sampled in IDLE.
  - rst asserted mid-burst aborts immediately to reset values; the partial result is discarded.
- Widths:
  - All bitwise operations are WIDTH bits.
  - The counter is CNT_W bits and never underflows, because it leaves ACCUM at 0.

Optional Feature:
- Macro: LOGIC_ACCUM_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit) = XOR of all out_data bits.
  - Registered together with out_data, with a reset value of 0.
  - Valid whenever out_valid=1.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=4, op=AND, len=1; words 4'b1111 then 4'b0011 → out_valid the cycle after the second accept; out_data=4'b0011. With parity enabled, out_parity=0.
- op=OR, len=2; words 4'b1100, 4'b0011, 4'b0000 → out_data=4'b1111. Hold out_ready=0 for 3 cycles: out_valid stays 1 and out_data is stable, then returns to IDLE after the handshake.
- op=XOR, len=3; words 4'b0101, 4'b0011, 4'b1111, 4'b0000, with in_valid deasserted for 2 cycles between words 2 and 3 → out_data=4'b1001, and no accept occurs while in_valid=0.
- op=NAND, len=0; word 4'b0101 → out_data=4'b1010. A start pulse during DONE is ignored and busy stays 1.
- Full-depth AND burst of 16 words (CNT_W=4), all 4'b1111 except word 9 = 4'b1101 → out_data=4'b1101 after exactly 16 accepts.
- Assert rst during word 2 of an OR burst → outputs zero immediately with busy=0. A new start after rst is released gives a correct result with no residue from the aborted burst.
